vector_checker: RTL and testbench
=================================

Name: vector_checker

Overview:
- Synthesizable response checker: the consuming end of the stimulus-vector reader path.
- Accepts DUT result / expected-value pairs each cycle, counts vectors and mismatches, and logs the first mismatches into a small FIFO for later readout.
- Declares pass/fail at end of run.
- Sits beside the DUT in lab benches and on-board self-test tops, fed by the vector reader.

Parameters:
- OUT_BITS, 8, width of DUT result and expected value
- MAX_VECTORS, 100, run auto-terminates after this many accepted vectors
- LOG_DEPTH, 8, mismatch log entries (power of two, >=2)
- CNT_W, 16, width of vector/error counters and log index

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  pulse: begin a run (clears counters and log)
- i_valid  in  1  vector pair present this cycle
- i_out  in  OUT_BITS  DUT result
- i_expected  in  OUT_BITS  expected result
- i_last  in  1  qualifies final vector of run (with i_valid)
- o_ready  out  1  checker accepts vectors (state RUN)
- o_busy  out  1  state RUN
- o_done  out  1  state DONE
- o_pass  out  1  valid when o_done: 1 if zero mismatches
- o_vec_count  out  CNT_W  accepted vectors this run
- o_err_count  out  CNT_W  mismatches this run
- o_log_overflow  out  1  a mismatch was dropped because log was full
- o_log_empty  out  1  log holds no entries
- i_log_rd  in  1  pop one log entry
- o_log_valid  out  1  o_log_* fields valid (one cycle after accepted pop)
- o_log_index  out  CNT_W  vector index of logged mismatch (0-based)
- o_log_out  out  OUT_BITS  logged DUT value
- o_log_expected  out  OUT_BITS  logged expected value

Behaviour:
- Reset: state IDLE; counters 0; o_pass 0; o_log_overflow 0; log empty; o_log_valid 0; o_log_* data 0.
- FSM states:
  - IDLE: i_start -> RUN.
  - RUN:
    - A vector is accepted when i_valid & o_ready.
    - Accepted with i_last, or accepted as vector number MAX_VECTORS (o_vec_count reaching MAX_VECTORS) -> DONE.
  - DONE: i_start -> RUN. Log and counters hold until then.
- i_start in RUN is ignored. i_start in IDLE/DONE clears counters, o_pass, overflow and log in the same edge that enters RUN.
- Compare: mismatch = (i_out != i_expected), full width.
- Timing:
  - Counters update on the edge accepting the vector; visible the next cycle.
  - o_done and o_pass are valid the cycle after the final accepted vector and include its result.
- Counters saturate at 2^CNT_W-1, never wrap. o_log_index is the pre-increment vector count.
- Log write:
  - Each accepted mismatch writes {index, out, expected} if log not full.
  - If full, the entry is dropped, o_err_count still increments, and o_log_overflow sets sticky until next i_start/reset.
- Log read:
  - i_log_rd with log non-empty pops the head. Data is registered: o_log_valid=1 next cycle, 1-cycle pulse.
  - i_log_rd on empty log is ignored; o_log_valid stays 0.
- Read and write in the same cycle are both performed. Full/empty decisions use occupancy before the edge, so a write to a full log in a pop cycle is dropped.
- Log readable in any state. Pointers wrap modulo LOG_DEPTH; occupancy counter is log2(LOG_DEPTH)+1 bits.
- i_valid outside RUN is ignored; no counters change.
- Reset mid-run: immediate return to IDLE with all reset values; in-flight data is discarded.

Optional Feature:
- Macro: VECTOR_CHECKER_STOP_ON_ERR_EN.
- Defined: first accepted mismatch also ends the run (RUN -> DONE next edge, o_pass=0). Subsequent vectors are not accepted.
- Undefined: run continues through all vectors regardless of mismatches.

Decomposition:
- Package vector_checker_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - packed struct log_entry_s {index [CNT_W], out [OUT_BITS], expected [OUT_BITS]}
  - default width constants
- Sub-module mismatch_log_fifo:
  - synchronous FIFO of log_entry_s, depth LOG_DEPTH
  - wr/rd, full/empty, registered read data + valid
  - same clock and sync reset, plus a clear input driven by i_start

Test Plan:
- Start, 5 matching vectors (0x11..0x15 both sides), last on 5th -> o_done next cycle, o_pass=1, o_vec_count=5, o_err_count=0, o_log_empty=1.
- 4 vectors, #1 and #3 mismatched (out 0xA5 vs exp 0x5A) -> o_err_count=2, o_pass=0. Two pops return index 1 then 3 with 0xA5/0x5A; o_log_valid exactly 1 cycle after each i_log_rd.
- LOG_DEPTH=8, 12 mismatching vectors -> o_err_count=12, 8 entries logged (indices 0..7), o_log_overflow=1. Ninth pop yields no o_log_valid.
- No i_last, MAX_VECTORS=100 -> DONE after 100th accepted vector, o_vec_count=100. i_valid afterwards changes nothing.
- i_reset asserted at vector 3 of a run -> next cycle IDLE, all counters 0, log empty. i_start then runs cleanly from index 0.
- With VECTOR_CHECKER_STOP_ON_ERR_EN, mismatch at vector 2 of 10 -> DONE, o_vec_count=3, o_err_count=1, o_ready=0. Without the macro -> o_vec_count=10.

Source files
------------

// File: rtl/vector_checker_pkg.sv
// Shared types and default widths for the vector checker slice.
//   state_e     : run-control FSM states
//   log_entry_s : one mismatch log record {index, out, expected}
package vector_checker_pkg;

   localparam int unsigned OUT_BITS_DEF    = 8;
   localparam int unsigned MAX_VECTORS_DEF = 100;
   localparam int unsigned LOG_DEPTH_DEF   = 8;
   localparam int unsigned CNT_W_DEF       = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic [CNT_W_DEF-1:0]    index;
      logic [OUT_BITS_DEF-1:0] out;
      logic [OUT_BITS_DEF-1:0] expected;
   } log_entry_s;

endpackage

// File: rtl/mismatch_log_fifo.sv
// Synchronous FIFO holding the first mismatches of a run.
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_clear          : empties the FIFO (start of a new run)
//   i_wr, i_wr_data  : push a record; ignored when full
//   i_rd             : pop head; ignored when empty
//   o_full, o_empty  : occupancy flags (state before the edge)
//   o_rd_valid       : one-cycle pulse the cycle after an accepted pop
//   o_rd_data        : registered head record
module mismatch_log_fifo
   import vector_checker_pkg::*;
#(
   parameter int unsigned DEPTH = LOG_DEPTH_DEF
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_clear,
   input  logic       i_wr,
   input  log_entry_s i_wr_data,
   input  logic       i_rd,
   output logic       o_full,
   output logic       o_empty,
   output logic       o_rd_valid,
   output log_entry_s o_rd_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   log_entry_s       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occ;
   logic             do_wr_c;
   logic             do_rd_c;

   assign o_full  = (occ == OCC_W'(DEPTH));
   assign o_empty = (occ == '0);

   // Clear wins over any same-cycle access so a new run starts from an empty log.
   assign do_wr_c = i_wr && !o_full && !i_clear;
   assign do_rd_c = i_rd && !o_empty && !i_clear;

   // Storage array, no reset needed: occupancy gates every read.
   always_ff @(posedge i_clk) begin
      if (do_wr_c) begin
         mem[wr_ptr] <= i_wr_data;
      end
   end

   // Pointers, occupancy and registered read port.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occ        <= '0;
         o_rd_valid <= 1'b0;
         o_rd_data  <= '0;
      end else if (i_clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occ        <= '0;
         o_rd_valid <= 1'b0;
      end else begin
         if (do_wr_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_rd_c) begin
            rd_ptr    <= rd_ptr + PTR_W'(1);
            o_rd_data <= mem[rd_ptr];
         end
         o_rd_valid <= do_rd_c;
         occ        <= occ + OCC_W'(do_wr_c) - OCC_W'(do_rd_c);
      end
   end

endmodule

// File: rtl/vector_checker.sv
// Response checker: compares DUT result against expected value per vector,
// counts vectors and mismatches, logs the first mismatches, and reports
// pass/fail at end of run.
//   i_clk, i_reset                : clock, synchronous active-high reset
//   i_start                       : begin a run (ignored while running)
//   i_valid, i_out, i_expected    : vector pair
//   i_last                        : final vector of the run
//   o_ready, o_busy, o_done       : run status
//   o_pass                        : zero mismatches (valid with o_done)
//   o_vec_count, o_err_count      : saturating run counters
//   o_log_overflow, o_log_empty   : log status
//   i_log_rd, o_log_*             : log readout, data valid the cycle after a pop
// Build option: VECTOR_CHECKER_STOP_ON_ERR_EN ends the run at the first mismatch.
module vector_checker
   import vector_checker_pkg::*;
#(
   parameter int unsigned OUT_BITS    = OUT_BITS_DEF,
   parameter int unsigned MAX_VECTORS = MAX_VECTORS_DEF,
   parameter int unsigned LOG_DEPTH   = LOG_DEPTH_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_valid,
   input  logic [OUT_BITS-1:0] i_out,
   input  logic [OUT_BITS-1:0] i_expected,
   input  logic                i_last,
   output logic                o_ready,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_pass,
   output logic [CNT_W-1:0]    o_vec_count,
   output logic [CNT_W-1:0]    o_err_count,
   output logic                o_log_overflow,
   output logic                o_log_empty,
   input  logic                i_log_rd,
   output logic                o_log_valid,
   output logic [CNT_W-1:0]    o_log_index,
   output logic [OUT_BITS-1:0] o_log_out,
   output logic [OUT_BITS-1:0] o_log_expected
);

`ifdef VECTOR_CHECKER_STOP_ON_ERR_EN
   localparam bit STOP_ON_ERR = 1'b1;
`else
   localparam bit STOP_ON_ERR = 1'b0;
`endif

   // The log record layout is fixed by the package; reject incompatible overrides.
   if (OUT_BITS != OUT_BITS_DEF || CNT_W != CNT_W_DEF) begin : g_width_guard
      $error("vector_checker: OUT_BITS/CNT_W must match vector_checker_pkg widths");
   end
   if (LOG_DEPTH < 2 || (LOG_DEPTH & (LOG_DEPTH - 1)) != 0) begin : g_depth_guard
      $error("vector_checker: LOG_DEPTH must be a power of two >= 2");
   end

   state_e           state;
   logic [CNT_W-1:0] vec_count;
   logic [CNT_W-1:0] err_count;
   logic             pass_q;
   logic             overflow_q;

   logic             start_c;
   logic             accept_c;
   logic             mismatch_c;
   logic             max_hit_c;
   logic             stop_c;
   logic             end_run_c;
   logic [CNT_W-1:0] vec_inc_c;
   logic [CNT_W-1:0] err_inc_c;
   logic             log_full_c;
   log_entry_s       wr_entry_c;
   log_entry_s       rd_entry_c;

   assign start_c    = i_start && (state != RUN);
   assign accept_c   = i_valid && (state == RUN);
   assign mismatch_c = accept_c && (i_out != i_expected);

   // This acceptance brings the count to MAX_VECTORS; extra bit avoids wrap at saturation.
   assign max_hit_c  = (({1'b0, vec_count} + (CNT_W+1)'(1)) == (CNT_W+1)'(MAX_VECTORS));
   assign stop_c     = STOP_ON_ERR && mismatch_c;
   assign end_run_c  = accept_c && (i_last || max_hit_c || stop_c);

   // Saturating increments.
   assign vec_inc_c  = (vec_count == '1) ? vec_count : vec_count + CNT_W'(1);
   assign err_inc_c  = (err_count == '1) ? err_count : err_count + CNT_W'(1);

   assign wr_entry_c = '{index: vec_count, out: i_out, expected: i_expected};

   // Run control, counters and verdict.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         vec_count  <= '0;
         err_count  <= '0;
         pass_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (i_start) begin
                  state      <= RUN;
                  vec_count  <= '0;
                  err_count  <= '0;
                  pass_q     <= 1'b0;
                  overflow_q <= 1'b0;
               end
            end
            RUN: begin
               if (accept_c) begin
                  vec_count <= vec_inc_c;
               end
               if (mismatch_c) begin
                  err_count <= err_inc_c;
                  if (log_full_c) begin
                     overflow_q <= 1'b1;
                  end
               end
               if (end_run_c) begin
                  state  <= DONE;
                  // Verdict includes the final vector's own compare.
                  pass_q <= (err_count == '0) && !mismatch_c;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   mismatch_log_fifo #(
      .DEPTH (LOG_DEPTH)
   ) u_log (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clear    (start_c),
      .i_wr       (mismatch_c),
      .i_wr_data  (wr_entry_c),
      .i_rd       (i_log_rd),
      .o_full     (log_full_c),
      .o_empty    (o_log_empty),
      .o_rd_valid (o_log_valid),
      .o_rd_data  (rd_entry_c)
   );

   assign o_ready        = (state == RUN);
   assign o_busy         = (state == RUN);
   assign o_done         = (state == DONE);
   assign o_pass         = pass_q;
   assign o_vec_count    = vec_count;
   assign o_err_count    = err_count;
   assign o_log_overflow = overflow_q;
   assign o_log_index    = rd_entry_c.index;
   assign o_log_out      = rd_entry_c.out;
   assign o_log_expected = rd_entry_c.expected;

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker: reference model of counters/verdict plus a
// scoreboard queue of expected log records, popped as the log is read out.
module tb_vector_checker;
   import vector_checker_pkg::*;

   localparam int unsigned OB   = 8;
   localparam int unsigned MAXV = 100;
   localparam int unsigned LD   = 8;
   localparam int unsigned CW   = 16;
`ifdef VECTOR_CHECKER_STOP_ON_ERR_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b0;
   logic          i_start = 1'b0;
   logic          i_valid = 1'b0;
   logic [OB-1:0] i_out = '0;
   logic [OB-1:0] i_expected = '0;
   logic          i_last = 1'b0;
   logic          i_log_rd = 1'b0;
   logic          o_ready, o_busy, o_done, o_pass;
   logic [CW-1:0] o_vec_count, o_err_count, o_log_index;
   logic          o_log_overflow, o_log_empty, o_log_valid;
   logic [OB-1:0] o_log_out, o_log_expected;

   vector_checker #(
      .OUT_BITS(OB), .MAX_VECTORS(MAXV), .LOG_DEPTH(LD), .CNT_W(CW)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_valid(i_valid),
      .i_out(i_out), .i_expected(i_expected), .i_last(i_last),
      .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
      .o_vec_count(o_vec_count), .o_err_count(o_err_count),
      .o_log_overflow(o_log_overflow), .o_log_empty(o_log_empty),
      .i_log_rd(i_log_rd), .o_log_valid(o_log_valid), .o_log_index(o_log_index),
      .o_log_out(o_log_out), .o_log_expected(o_log_expected)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int         m_vec = 0;
   int         m_err = 0;
   bit         m_run = 1'b0;
   bit         m_done = 1'b0;
   bit         m_ovf = 1'b0;
   log_entry_s sb_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic model_clear();
      m_vec = 0;
      m_err = 0;
      m_ovf = 1'b0;
      m_done = 1'b0;
      sb_q.delete();
   endtask

   task automatic do_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      model_clear();
      m_run = 1'b1;
   endtask

   task automatic send(input logic [OB-1:0] o, input logic [OB-1:0] e, input bit last);
      log_entry_s ent;
      i_valid = 1'b1;
      i_out = o;
      i_expected = e;
      i_last = last;
      tick();
      i_valid = 1'b0;
      i_last = 1'b0;
      if (m_run) begin
         if (o != e) begin
            if (sb_q.size() < LD) begin
               ent = '{index: 16'(m_vec), out: o, expected: e};
               sb_q.push_back(ent);
            end else begin
               m_ovf = 1'b1;
            end
            if (m_err < 65535) m_err++;
         end
         if (m_vec < 65535) m_vec++;
         if (last || m_vec == MAXV || (STOP && o != e)) begin
            m_run = 1'b0;
            m_done = 1'b1;
         end
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, "_vec"},   32'(o_vec_count),    32'(m_vec));
      check({tag, "_err"},   32'(o_err_count),    32'(m_err));
      check({tag, "_done"},  32'(o_done),         32'(m_done));
      check({tag, "_pass"},  32'(o_pass),         32'(m_done && m_err == 0));
      check({tag, "_ovf"},   32'(o_log_overflow), 32'(m_ovf));
      check({tag, "_empty"}, 32'(o_log_empty),    32'(sb_q.size() == 0));
      check({tag, "_ready"}, 32'(o_ready),        32'(m_run));
      check({tag, "_busy"},  32'(o_busy),         32'(m_run));
   endtask

   task automatic pop_check(input string tag);
      log_entry_s e;
      i_log_rd = 1'b1;
      tick();
      i_log_rd = 1'b0;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, "_valid"}, 32'(o_log_valid),    32'd1);
         check({tag, "_index"}, 32'(o_log_index),    32'(e.index));
         check({tag, "_out"},   32'(o_log_out),      32'(e.out));
         check({tag, "_exp"},   32'(o_log_expected), 32'(e.expected));
      end else begin
         check({tag, "_novalid"}, 32'(o_log_valid), 32'd0);
      end
      tick();
      check({tag, "_pulse"}, 32'(o_log_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values
      i_reset = 1'b1;
      tick();
      tick();
      i_reset = 1'b0;
      check_status("reset");
      check("reset_lvalid", 32'(o_log_valid), 32'd0);
      check("reset_lidx",   32'(o_log_index), 32'd0);
      check("reset_lout",   32'(o_log_out),   32'd0);

      // Five matching vectors, last on the fifth
      do_start();
      for (int i = 0; i < 5; i++) send(8'(8'h11 + i), 8'(8'h11 + i), i == 4);
      check_status("match5");

      // Four vectors with #1 and #3 mismatched
      do_start();
      for (int i = 0; i < 4; i++) begin
         if (i == 1 || i == 3) send(8'hA5, 8'h5A, i == 3);
         else                  send(8'(i), 8'(i), i == 3);
      end
      check_status("mm2");
      pop_check("mm2_pop0");
      pop_check("mm2_pop1");
      pop_check("mm2_pop2");

      // Twelve mismatches overflow an eight-deep log
      do_start();
      for (int i = 0; i < 12; i++) send(8'(i), 8'(~i), i == 11);
      check_status("ovf");
      for (int i = 0; i < 9; i++) pop_check($sformatf("ovf_pop%0d", i));
      check_status("ovf_drained");

      // Auto-terminate at MAX_VECTORS; later vectors ignored
      do_start();
      for (int i = 0; i < MAXV; i++) send(8'(i), 8'(i), 1'b0);
      check_status("max");
      for (int i = 0; i < 3; i++) send(8'h01, 8'h02, 1'b0);
      check_status("max_after");

      // Reset mid-run discards everything
      do_start();
      send(8'h10, 8'h10, 1'b0);
      send(8'h20, 8'h21, 1'b0);
      send(8'h30, 8'h30, 1'b0);
      i_reset = 1'b1;
      i_valid = 1'b1;
      i_out = 8'hFF;
      i_expected = 8'h00;
      tick();
      i_reset = 1'b0;
      i_valid = 1'b0;
      model_clear();
      m_run = 1'b0;
      check_status("rstmid");
      check("rstmid_lvalid", 32'(o_log_valid), 32'd0);
      do_start();
      send(8'h33, 8'h44, 1'b0);
      send(8'h55, 8'h55, 1'b1);
      check_status("rerun");
      pop_check("rerun_pop0");

      // Mismatch at index 2 of 10
      do_start();
      for (int i = 0; i < 10; i++) begin
         if (i == 2) send(8'hC3, 8'h3C, i == 9);
         else        send(8'(i), 8'(i), i == 9);
      end
      check_status("stop");
      check("stop_vec_abs", 32'(o_vec_count), STOP ? 32'd3 : 32'd10);
      check("stop_err_abs", 32'(o_err_count), 32'd1);
      check("stop_ready",   32'(o_ready),     32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
